// File: rtl/dla_cmd_regbank.sv
// dla_cmd_regbank - command register bank for the DLA control path.
//
// Decodes the SoC register bus into a global block (STATUS, INTR, INTR_EN) and NUM_CH engine
// channel windows. Each channel owns an IDLE/BUSY sequencer that launches its engine with a
// one-cycle go pulse and collects the done pulse into a sticky interrupt bit.
//
// Optional feature macro: DLA_REGBANK_SHADOW_EN
//   defined   : configuration writes land in a per-channel shadow copy that is transferred to
//               the active copy at launch; a one-deep pending-go queue relaunches on done.
//   undefined : configuration writes go straight to the active copy; go while busy is dropped
//               and flagged as overflow; the pending flag always reads 0.
//
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_reg_wr_en, i_reg_rd_en write / read strobes, one word per cycle
//   i_reg_addr, i_reg_wdata  word address and write data
//   o_reg_rdata, o_reg_rvalid read data and its valid, one cycle after the read strobe
//   o_ch_cfg                 active configuration words, word 0 of each channel is 0
//   o_ch_go                  one-cycle launch pulse per channel
//   i_ch_done                one-cycle completion pulse per channel
//   o_intr                   registered level interrupt
module dla_cmd_regbank #(
  parameter int unsigned       NUM_CH      = 8,
  parameter int unsigned       REGS_PER_CH = 16,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] CH_BASE     = ADDR_W'(32'h0000_1000)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_reg_wr_en,
  input  logic                                 i_reg_rd_en,
  input  logic [ADDR_W-1:0]                    i_reg_addr,
  input  logic [DATA_W-1:0]                    i_reg_wdata,
  output logic [DATA_W-1:0]                    o_reg_rdata,
  output logic                                 o_reg_rvalid,
  output logic [NUM_CH*REGS_PER_CH*DATA_W-1:0] o_ch_cfg,
  output logic [NUM_CH-1:0]                    o_ch_go,
  input  logic [NUM_CH-1:0]                    i_ch_done,
  output logic                                 o_intr
);

  localparam int unsigned       ChIdxW     = ADDR_W - 4;
  localparam logic [ADDR_W-1:0] AddrStatus = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrIntr   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrIntrEn = ADDR_W'(2);
`ifdef DLA_REGBANK_SHADOW_EN
  localparam bit ShadowEn = 1'b1;
`else
  localparam bit ShadowEn = 1'b0;
`endif

  typedef enum logic {StIdle, StBusy} ch_state_e;

  ch_state_e         r_state   [NUM_CH];
  ch_state_e         w_state_d [NUM_CH];
  logic [NUM_CH-1:0] r_pend, w_pend_d;
  logic [NUM_CH-1:0] r_go, w_launch;
  logic [NUM_CH-1:0] w_go_req, w_busy, w_done_set, w_ovf_set;
  logic [NUM_CH-1:0] r_intr_bits, w_intr_d;
  logic [NUM_CH-1:0] r_ovf, w_ovf_d;
  logic [15:0]       r_intr_en, w_intr_en_d;
  logic              r_intr;
  logic [DATA_W-1:0] r_active [NUM_CH][REGS_PER_CH];
`ifdef DLA_REGBANK_SHADOW_EN
  logic [DATA_W-1:0] r_shadow [NUM_CH][REGS_PER_CH];
`endif
  logic [DATA_W-1:0] r_rdata, w_rdata;
  logic              r_rvalid;

  logic [ADDR_W-1:0] w_ch_off;
  logic [3:0]        w_ch_sel, w_reg_sel;
  logic              w_ch_ok, w_wr_intr, w_wr_intr_en;

  // Channel windows sit on a fixed 16-word stride regardless of REGS_PER_CH.
  always_comb begin
    w_ch_off     = i_reg_addr - CH_BASE;
    w_ch_sel     = w_ch_off[7:4];
    w_reg_sel    = w_ch_off[3:0];
    w_ch_ok      = (i_reg_addr >= CH_BASE) &&
                   (w_ch_off[ADDR_W-1:4] < ChIdxW'(NUM_CH)) &&
                   ({1'b0, w_reg_sel} < 5'(REGS_PER_CH));
    w_wr_intr    = i_reg_wr_en && (i_reg_addr == AddrIntr);
    w_wr_intr_en = i_reg_wr_en && (i_reg_addr == AddrIntrEn);
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_go_req[c] = i_reg_wr_en && w_ch_ok && (w_ch_sel == 4'(c)) && (w_reg_sel == 4'd0) &&
                    i_reg_wdata[31];
      w_busy[c]   = (r_state[c] == StBusy);
    end
  end

  // Per-channel sequencer. Done is resolved before go so that a same-cycle done and go on a
  // busy channel relaunches immediately instead of queueing or overflowing.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_state_d[c]  = r_state[c];
      w_pend_d[c]   = r_pend[c];
      w_launch[c]   = 1'b0;
      w_done_set[c] = 1'b0;
      w_ovf_set[c]  = 1'b0;
      if (r_state[c] == StBusy && i_ch_done[c]) begin
        w_done_set[c] = 1'b1;
        if (r_pend[c]) begin
          w_pend_d[c] = 1'b0;
          w_launch[c] = 1'b1;
        end else begin
          w_state_d[c] = StIdle;
        end
      end
      if (w_go_req[c]) begin
        if (w_state_d[c] == StIdle) begin
          w_launch[c]  = 1'b1;
          w_state_d[c] = StBusy;
        end else if (ShadowEn && !w_pend_d[c]) begin
          w_pend_d[c] = 1'b1;
        end else begin
          w_ovf_set[c] = 1'b1;
        end
      end
    end
  end

  // Sticky bits: clears first, then sets, so a same-cycle event always survives.
  always_comb begin
    w_intr_d    = r_intr_bits;
    w_ovf_d     = r_ovf;
    w_intr_en_d = r_intr_en;
    if (w_wr_intr) begin
      w_intr_d = r_intr_bits & ~i_reg_wdata[NUM_CH-1:0];
      if (i_reg_wdata[31]) begin
        w_ovf_d = '0;
      end
    end
    if (w_wr_intr_en) begin
      w_intr_en_d = i_reg_wdata[15:0];
    end
    w_intr_d = w_intr_d | w_done_set;
    w_ovf_d  = w_ovf_d | w_ovf_set;
  end

  // Read mux works on pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    w_rdata = '0;
    if (i_reg_addr == AddrStatus) begin
      w_rdata[31:16] = 16'(r_ovf);
      w_rdata[15:0]  = 16'(w_busy);
    end else if (i_reg_addr == AddrIntr) begin
      w_rdata[15:0] = 16'(r_intr_bits);
    end else if (i_reg_addr == AddrIntrEn) begin
      w_rdata[15:0] = r_intr_en;
    end else if (w_ch_ok) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ch_sel == 4'(c)) begin
          if (w_reg_sel == 4'd0) begin
            w_rdata[31] = w_busy[c];
            w_rdata[30] = r_pend[c];
          end
          for (int r = 1; r < REGS_PER_CH; r++) begin
            if (w_reg_sel == 4'(r)) begin
`ifdef DLA_REGBANK_SHADOW_EN
              w_rdata = r_shadow[c][r];
`else
              w_rdata = r_active[c][r];
`endif
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c] <= StIdle;
        for (int r = 0; r < REGS_PER_CH; r++) begin
          r_active[c][r] <= '0;
`ifdef DLA_REGBANK_SHADOW_EN
          r_shadow[c][r] <= '0;
`endif
        end
      end
      r_pend      <= '0;
      r_go        <= '0;
      r_intr_bits <= '0;
      r_ovf       <= '0;
      r_intr_en   <= '0;
      r_intr      <= 1'b0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c] <= w_state_d[c];
        for (int r = 1; r < REGS_PER_CH; r++) begin
`ifdef DLA_REGBANK_SHADOW_EN
          // Launch copies the shadow as it was before this edge's write.
          if (w_launch[c]) begin
            r_active[c][r] <= r_shadow[c][r];
          end
          if (i_reg_wr_en && w_ch_ok && w_ch_sel == 4'(c) && w_reg_sel == 4'(r)) begin
            r_shadow[c][r] <= i_reg_wdata;
          end
`else
          if (i_reg_wr_en && w_ch_ok && w_ch_sel == 4'(c) && w_reg_sel == 4'(r)) begin
            r_active[c][r] <= i_reg_wdata;
          end
`endif
        end
      end
      r_pend      <= w_pend_d;
      r_go        <= w_launch;
      r_intr_bits <= w_intr_d;
      r_ovf       <= w_ovf_d;
      r_intr_en   <= w_intr_en_d;
      r_intr      <= |(w_intr_d & w_intr_en_d[NUM_CH-1:0]);
      r_rvalid    <= i_reg_rd_en;
      r_rdata     <= i_reg_rd_en ? w_rdata : '0;
    end
  end

  always_comb begin
    o_ch_cfg = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int r = 1; r < REGS_PER_CH; r++) begin
        o_ch_cfg[(c*REGS_PER_CH + r)*DATA_W +: DATA_W] = r_active[c][r];
      end
    end
  end

  assign o_reg_rdata  = r_rdata;
  assign o_reg_rvalid = r_rvalid;
  assign o_ch_go      = r_go;
  assign o_intr       = r_intr;

endmodule

// File: tb/tb_dla_cmd_regbank.sv
// Self-checking bench for dla_cmd_regbank at default parameters. Directed scenarios follow the
// block's operating rules; a randomized phase is checked every cycle against a behavioural model.
module tb_dla_cmd_regbank;

  localparam int NCH = 8;
  localparam int NR  = 16;
  localparam int DW  = 32;
`ifdef DLA_REGBANK_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [19:0]       addr = '0;
  logic [31:0]       wdata = '0;
  logic [NCH-1:0]    done = '0;
  logic [31:0]       rdata;
  logic              rvalid;
  logic [NCH*NR*DW-1:0] cfg;
  logic [NCH-1:0]    go;
  logic              intr;

  int n_checks = 0;
  int n_fail   = 0;

  dla_cmd_regbank dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_reg_wr_en  (wr_en),
    .i_reg_rd_en  (rd_en),
    .i_reg_addr   (addr),
    .i_reg_wdata  (wdata),
    .o_reg_rdata  (rdata),
    .o_reg_rvalid (rvalid),
    .o_ch_cfg     (cfg),
    .o_ch_go      (go),
    .i_ch_done    (done),
    .o_intr       (intr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim_time=%0t limit=1000000", $time);
    $fatal(1, "timeout");
  end

  // Behavioural model state.
  logic [31:0]    m_shadow [NCH][NR];
  logic [31:0]    m_active [NCH][NR];
  logic [NCH-1:0] m_busy, m_pend, m_intr, m_ovf;
  logic [15:0]    m_en;
  logic [31:0]    exp_rdata;
  logic           exp_rvalid, exp_intr;
  logic [NCH-1:0] exp_go;

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int r = 0; r < NR; r++) begin
        m_shadow[c][r] = '0;
        m_active[c][r] = '0;
      end
    end
    m_busy = '0; m_pend = '0; m_intr = '0; m_ovf = '0; m_en = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [19:0] a);
    int off, c, r;
    if (a == 20'h0) return {8'h0, m_ovf, 8'h0, m_busy};
    if (a == 20'h1) return {24'h0, m_intr};
    if (a == 20'h2) return {16'h0, m_en};
    if (a < 20'h01000) return 32'h0;
    off = int'(a) - 32'h1000;
    c = off / 16;
    r = off % 16;
    if (c >= NCH) return 32'h0;
    if (r == 0) return {m_busy[c], m_pend[c], 30'h0};
    return SHADOW ? m_shadow[c][r] : m_active[c][r];
  endfunction

  function automatic logic [NCH*NR*DW-1:0] m_cfg();
    logic [NCH*NR*DW-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++)
      for (int r = 1; r < NR; r++) v[(c*NR + r)*DW +: DW] = m_active[c][r];
    return v;
  endfunction

  task automatic m_launch(input int ch);
    if (SHADOW) for (int r = 0; r < NR; r++) m_active[ch][r] = m_shadow[ch][r];
    exp_go[ch] = 1'b1;
  endtask

  // One bus cycle as seen by software: read returns old state, clears precede sets,
  // done is handled before go, a launch copies the configuration held before this write.
  task automatic m_step(input bit wr, input bit rd, input logic [19:0] a, input logic [31:0] d,
                        input logic [NCH-1:0] dn);
    int off, c, r;
    bit in_ch;
    exp_rvalid = rd;
    exp_rdata  = rd ? m_read(a) : 32'h0;
    exp_go     = '0;
    in_ch = 1'b0; c = 0; r = 0;
    if (a >= 20'h01000) begin
      off = int'(a) - 32'h1000;
      c = off / 16;
      r = off % 16;
      in_ch = (c < NCH);
    end
    if (wr && a == 20'h1) begin
      m_intr = m_intr & ~d[NCH-1:0];
      if (d[31]) m_ovf = '0;
    end
    if (wr && a == 20'h2) m_en = d[15:0];
    for (int ch = 0; ch < NCH; ch++) begin
      if (m_busy[ch] && dn[ch]) begin
        m_intr[ch] = 1'b1;
        if (m_pend[ch]) begin
          m_pend[ch] = 1'b0;
          m_launch(ch);
        end else begin
          m_busy[ch] = 1'b0;
        end
      end
      if (wr && in_ch && c == ch && r == 0 && d[31]) begin
        if (!m_busy[ch]) begin
          m_busy[ch] = 1'b1;
          m_launch(ch);
        end else if (SHADOW && !m_pend[ch]) begin
          m_pend[ch] = 1'b1;
        end else begin
          m_ovf[ch] = 1'b1;
        end
      end
    end
    if (wr && in_ch && r != 0) begin
      if (SHADOW) m_shadow[c][r] = d;
      else m_active[c][r] = d;
    end
    exp_intr = |(m_intr & m_en[NCH-1:0]);
  endtask

  // Drive one cycle (called #1 after a rising edge), return #1 after the next rising edge.
  task automatic drive(input bit wr, input bit rd, input logic [19:0] a, input logic [31:0] d,
                       input logic [NCH-1:0] dn);
    wr_en = wr; rd_en = rd; addr = a; wdata = d; done = dn;
    m_step(wr, rd, a, d, dn);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; done = '0;
  endtask

  task automatic test_reset();
    logic [19:0] ra [3];
    ra[0] = 20'h00000; ra[1] = 20'h00001; ra[2] = 20'h01010;
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got=%b exp=0", rvalid); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    n_checks++; if (go !== '0) begin n_fail++; $display("FAIL rst_go got=%h exp=0", go); end
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL rst_intr got=%b exp=0", intr); end
    n_checks++; if (cfg !== '0) begin n_fail++; $display("FAIL rst_cfg got=nonzero exp=0"); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, ra[i], 32'h0, '0);
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h0) begin
        n_fail++; $display("FAIL rst_read a=%h got=%b/%h exp=1/0", ra[i], rvalid, rdata);
      end
    end
    drive(1'b0, 1'b0, 20'h0, 32'h0, '0);
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_drop got=%b exp=0", rvalid); end
  endtask

  task automatic test_launch();
    drive(1'b1, 1'b0, 20'h01011, 32'hDEAD_BEEF, '0);
    n_checks++; if (go !== 8'h00) begin n_fail++; $display("FAIL cfg_wr_go got=%h exp=00", go); end
    drive(1'b1, 1'b0, 20'h01010, 32'h8000_0000, '0);
    n_checks++; if (go !== 8'h02) begin n_fail++; $display("FAIL launch_go got=%h exp=02", go); end
    n_checks++;
    if (cfg[(1*NR + 1)*DW +: DW] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL launch_cfg got=%h exp=deadbeef", cfg[(1*NR + 1)*DW +: DW]);
    end
    drive(1'b0, 1'b1, 20'h00000, 32'h0, '0);
    n_checks++; if (go !== 8'h00) begin n_fail++; $display("FAIL go_pulse got=%h exp=00", go); end
    n_checks++; if (rdata !== 32'h2) begin n_fail++; $display("FAIL status_busy got=%h exp=2", rdata); end
    drive(1'b0, 1'b1, 20'h01010, 32'h0, '0);
    n_checks++;
    if (rdata !== 32'h8000_0000) begin n_fail++; $display("FAIL ctrl_busy got=%h exp=80000000", rdata); end
  endtask

  task automatic test_pending();
    logic [31:0] e;
    drive(1'b1, 1'b0, 20'h01011, 32'h1234_5678, '0);
    e = SHADOW ? 32'hDEAD_BEEF : 32'h1234_5678;
    n_checks++;
    if (cfg[(1*NR + 1)*DW +: DW] !== e) begin
      n_fail++; $display("FAIL busy_cfg got=%h exp=%h", cfg[(1*NR + 1)*DW +: DW], e);
    end
    drive(1'b1, 1'b0, 20'h01010, 32'h8000_0000, '0);
    n_checks++; if (go !== 8'h00) begin n_fail++; $display("FAIL busy_go got=%h exp=00", go); end
    drive(1'b0, 1'b1, 20'h01010, 32'h0, '0);
    e = SHADOW ? 32'hC000_0000 : 32'h8000_0000;
    n_checks++; if (rdata !== e) begin n_fail++; $display("FAIL pend_ctrl got=%h exp=%h", rdata, e); end
    drive(1'b0, 1'b0, 20'h0, 32'h0, 8'h02);
    e = SHADOW ? 32'h2 : 32'h0;
    n_checks++; if (go !== e[7:0]) begin n_fail++; $display("FAIL relaunch_go got=%h exp=%h", go, e[7:0]); end
    n_checks++;
    if (cfg[(1*NR + 1)*DW +: DW] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL relaunch_cfg got=%h exp=12345678", cfg[(1*NR + 1)*DW +: DW]);
    end
    drive(1'b0, 1'b1, 20'h00001, 32'h0, '0);
    n_checks++; if (rdata !== 32'h2) begin n_fail++; $display("FAIL done_intr got=%h exp=2", rdata); end
    drive(1'b0, 1'b1, 20'h00000, 32'h0, '0);
    e = SHADOW ? 32'h0000_0002 : 32'h0002_0000;
    n_checks++; if (rdata !== e) begin n_fail++; $display("FAIL done_status got=%h exp=%h", rdata, e); end
  endtask

  task automatic test_overflow();
    logic [7:0] eg;
    drive(1'b1, 1'b0, 20'h01010, 32'h8000_0000, '0);
    eg = SHADOW ? 8'h00 : 8'h02;
    n_checks++; if (go !== eg) begin n_fail++; $display("FAIL ovf_go1 got=%h exp=%h", go, eg); end
    drive(1'b1, 1'b0, 20'h01010, 32'h8000_0000, '0);
    n_checks++; if (go !== 8'h00) begin n_fail++; $display("FAIL ovf_go2 got=%h exp=00", go); end
    drive(1'b0, 1'b1, 20'h00000, 32'h0, '0);
    n_checks++;
    if (rdata !== 32'h0002_0002) begin n_fail++; $display("FAIL ovf_status got=%h exp=00020002", rdata); end
    drive(1'b1, 1'b0, 20'h00001, 32'h8000_0000, '0);
    drive(1'b0, 1'b1, 20'h00000, 32'h0, '0);
    n_checks++;
    if (rdata !== 32'h0000_0002) begin n_fail++; $display("FAIL ovf_clear got=%h exp=00000002", rdata); end
    drive(1'b0, 1'b1, 20'h00001, 32'h0, '0);
    n_checks++; if (rdata !== 32'h2) begin n_fail++; $display("FAIL ovf_intr_kept got=%h exp=2", rdata); end
  endtask

  task automatic test_intr();
    drive(1'b1, 1'b0, 20'h00002, 32'h0000_0004, '0);
    drive(1'b1, 1'b0, 20'h01020, 32'h8000_0000, '0);
    n_checks++; if (go !== 8'h04) begin n_fail++; $display("FAIL ch2_go got=%h exp=04", go); end
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL intr_masked got=%b exp=0", intr); end
    drive(1'b0, 1'b0, 20'h0, 32'h0, 8'h04);
    n_checks++; if (intr !== 1'b1) begin n_fail++; $display("FAIL intr_set got=%b exp=1", intr); end
    drive(1'b1, 1'b0, 20'h00001, 32'h0000_0004, '0);
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL intr_w1c got=%b exp=0", intr); end
    drive(1'b1, 1'b0, 20'h01020, 32'h8000_0000, '0);
    drive(1'b1, 1'b0, 20'h00001, 32'h0000_0004, 8'h04);
    n_checks++; if (intr !== 1'b1) begin n_fail++; $display("FAIL set_wins got=%b exp=1", intr); end
    drive(1'b0, 1'b1, 20'h00001, 32'h0, '0);
    n_checks++; if (rdata !== 32'h6) begin n_fail++; $display("FAIL intr_reg got=%h exp=6", rdata); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 20'h01020, 32'h8000_0000, '0);
    n_checks++; if (go !== 8'h04) begin n_fail++; $display("FAIL b2b_go1 got=%h exp=04", go); end
    drive(1'b1, 1'b0, 20'h01023, 32'hA5A5_A5A5, '0);
    drive(1'b1, 1'b0, 20'h01020, 32'h8000_0000, 8'h04);
    n_checks++; if (go !== 8'h04) begin n_fail++; $display("FAIL b2b_go2 got=%h exp=04", go); end
    n_checks++;
    if (cfg[(2*NR + 3)*DW +: DW] !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL b2b_cfg got=%h exp=a5a5a5a5", cfg[(2*NR + 3)*DW +: DW]);
    end
    drive(1'b0, 1'b1, 20'h01020, 32'h0, '0);
    n_checks++;
    if (rdata !== 32'h8000_0000) begin n_fail++; $display("FAIL b2b_ctrl got=%h exp=80000000", rdata); end
  endtask

  task automatic test_unmapped();
    logic [NCH*NR*DW-1:0] snap;
    logic [19:0] ua [3];
    ua[0] = 20'h01234; ua[1] = 20'h01080; ua[2] = 20'h00003;
    snap = cfg;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, ua[i], 32'hFFFF_FFFF, '0);
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h0) begin
        n_fail++; $display("FAIL unmapped_rd a=%h got=%b/%h exp=1/0", ua[i], rvalid, rdata);
      end
      drive(1'b0, 1'b1, ua[i], 32'h0, '0);
      n_checks++;
      if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd2 a=%h got=%h exp=0", ua[i], rdata); end
    end
    n_checks++; if (cfg !== snap) begin n_fail++; $display("FAIL unmapped_cfg got=changed exp=unchanged"); end
  endtask

  task automatic test_rw_same();
    drive(1'b1, 1'b0, 20'h01025, 32'h1111_1111, '0);
    drive(1'b1, 1'b1, 20'h01025, 32'h2222_2222, '0);
    n_checks++; if (rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL rw_old got=%h exp=11111111", rdata); end
    drive(1'b0, 1'b1, 20'h01025, 32'h0, '0);
    n_checks++; if (rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL rw_new got=%h exp=22222222", rdata); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 20'h01030, 32'h8000_0000, '0);
    n_checks++; if (go !== 8'h08) begin n_fail++; $display("FAIL mid_go got=%h exp=08", go); end
    rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; addr = 20'h01010; wdata = 32'h8000_0000; done = '1;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; done = '0;
    m_reset();
    n_checks++; if (go !== 8'h00) begin n_fail++; $display("FAIL mid_rst_go got=%h exp=00", go); end
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL mid_rst_intr got=%b exp=0", intr); end
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rvalid got=%b exp=0", rvalid); end
    n_checks++; if (cfg !== '0) begin n_fail++; $display("FAIL mid_rst_cfg got=nonzero exp=0"); end
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 20'h00000, 32'h0, '0);
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rst_status got=%h exp=0", rdata); end
  endtask

  task automatic test_random();
    logic [NCH*NR*DW-1:0] ec;
    logic [19:0] a;
    logic [31:0] d;
    logic [NCH-1:0] dn;
    bit w, rd;
    int sel, fw;
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) a = 20'h0;
      else if (sel == 1) a = 20'h1;
      else if (sel == 2) a = 20'h2;
      else if ($urandom_range(0, 2) == 0) a = 20'h01000 + 20'($urandom_range(0, 8) * 16);
      else a = 20'h01000 + 20'($urandom_range(0, 8) * 16 + $urandom_range(0, 15));
      d  = $urandom;
      w  = ($urandom_range(0, 9) < 6);
      rd = ($urandom_range(0, 1) == 1);
      for (int c = 0; c < NCH; c++) dn[c] = ($urandom_range(0, 5) == 0);
      drive(w, rd, a, d, dn);
      ec = m_cfg();
      n_checks++; if (go !== exp_go) begin n_fail++; $display("FAIL rand_go i=%0d got=%h exp=%h", i, go, exp_go); end
      n_checks++;
      if (intr !== exp_intr) begin n_fail++; $display("FAIL rand_intr i=%0d got=%b exp=%b", i, intr, exp_intr); end
      n_checks++;
      if (rvalid !== exp_rvalid) begin
        n_fail++; $display("FAIL rand_rvalid i=%0d got=%b exp=%b", i, rvalid, exp_rvalid);
      end
      if (exp_rvalid) begin
        n_checks++;
        if (rdata !== exp_rdata) begin
          n_fail++; $display("FAIL rand_rdata i=%0d a=%h got=%h exp=%h", i, a, rdata, exp_rdata);
        end
      end
      n_checks++;
      if (cfg !== ec) begin
        n_fail++;
        fw = 0;
        for (int k = NCH*NR - 1; k >= 0; k--) if (cfg[k*DW +: DW] !== ec[k*DW +: DW]) fw = k;
        $display("FAIL rand_cfg i=%0d word=%0d got=%h exp=%h", i, fw, cfg[fw*DW +: DW],
                 ec[fw*DW +: DW]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_pending();
    test_overflow();
    test_intr();
    test_back_to_back();
    test_unmapped();
    test_rw_same();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
